// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states, access-size encodings and the
// byte-offset width helper used to split a byte address into word address and lane.
package pipeline_pkg;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam int   CNT_W    = 3;
  localparam logic ACC_BYTE = 1'b1;
  localparam logic ACC_WORD = 1'b0;

  function automatic int byte_off_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/mem_stage_ws_data_sram.sv
// Single-port data RAM: per-byte write enables, registered read port, no reset on contents.
module data_sram #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [DW/8-1:0]   i_be,
  input  logic [AW-1:0]     i_addr,
  input  logic [DW-1:0]     i_wdata,
  output logic [DW-1:0]     o_rdata
);

  localparam int NB = DW / 8;

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: EX/MEM -> MEM/WB register with byte/word data-memory access,
// misalign detection and a wait-state FSM that freezes upstream while an access is pending.
module mem_stage_ws
  import pipeline_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 8,
  parameter int RW          = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_res,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_op_dest,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic          ex_byte,
  input  logic          ex_sign,
  input  logic          ex_wb_mux,
  input  logic          ex_wb_en,
  output logic          mem_stall,
  output logic          mem_valid,
  output logic          mem_wb_mux,
  output logic          mem_wb_en,
  output logic [RW-1:0] mem_op_dest,
  output logic [DW-1:0] mem_alu_res,
  output logic [DW-1:0] mem_load_data,
  output logic          mem_misalign
);

  localparam int NB = DW / 8;
  localparam int BO = byte_off_bits(DW);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [BO-1:0]    w_off;
  logic [AW-1:0]    w_addr;
  logic             w_is_byte;
  logic             w_mem_op;
  logic             w_misalign;
  logic             w_aligned_mem;
  logic             w_is_load;
  logic             w_stall;
  logic             w_fire;
  logic             w_we;
  logic             w_re;
  logic [NB-1:0]    w_be;
  logic [DW-1:0]    w_wdata;
  logic [DW-1:0]    w_rdata;

  logic             r_vld_p1;
  logic             r_wb_mux_p1;
  logic             r_wb_en_p1;
  logic [RW-1:0]    r_op_dest_p1;
  logic [DW-1:0]    r_alu_res_p1;
  logic             r_misalign_p1;
  logic             r_is_load_p1;
  logic [BO-1:0]    r_off_p1;
  logic             r_sign_p1;
  logic             r_byte_p1;

  // Lane select plus sign/zero extension of the raw RAM word.
  function automatic logic [DW-1:0] fmt_load(input logic [DW-1:0] word,
                                             input logic [BO-1:0] off,
                                             input logic          is_byte,
                                             input logic          sgn);
    logic signed [7:0]    lane;
    logic signed [DW-1:0] sext;
    lane = word[int'(off)*8 +: 8];
    sext = lane;
    if (!is_byte) return word;
    if (sgn)      return sext;
    return {{(DW-8){1'b0}}, lane};
  endfunction

  assign w_off         = ex_alu_res[BO-1:0];
  assign w_addr        = ex_alu_res[BO+AW-1:BO];
  assign w_is_byte     = (ex_byte == ACC_BYTE);
  assign w_mem_op      = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign w_misalign    = w_mem_op & ~w_is_byte & (w_off != '0);
  assign w_aligned_mem = w_mem_op & ~w_misalign;
  assign w_is_load     = w_aligned_mem & ex_mem_rd & ~ex_mem_wr;

  always_comb begin
    w_stall = 1'b0;
    if (WAIT_STATES != 0 && !rst) begin
      if (r_state == S_IDLE) w_stall = w_aligned_mem;
      else                   w_stall = (r_cnt != '0);
    end
  end

  assign mem_stall = w_stall;
  assign w_fire    = ~w_stall & ~rst;
  assign w_we      = w_fire & w_aligned_mem & ex_mem_wr;
  assign w_re      = w_fire & w_is_load;
  assign w_be      = w_is_byte ? ({{(NB-1){1'b0}}, 1'b1} << w_off) : '1;
  assign w_wdata   = w_is_byte ? {NB{ex_store_data[7:0]}} : ex_store_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (WAIT_STATES != 0) begin
      case (r_state)
        S_IDLE: if (w_aligned_mem) begin
          r_cnt   <= CNT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                else             r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  data_sram #(.DW(DW), .AW(AW)) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_be    (w_be),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // EX/MEM -> MEM/WB boundary; a stalled edge inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_stall) begin
      r_vld_p1      <= 1'b0;
      r_wb_mux_p1   <= 1'b0;
      r_wb_en_p1    <= 1'b0;
      r_op_dest_p1  <= '0;
      r_alu_res_p1  <= '0;
      r_misalign_p1 <= 1'b0;
      r_is_load_p1  <= 1'b0;
      r_off_p1      <= '0;
      r_sign_p1     <= 1'b0;
      r_byte_p1     <= 1'b0;
    end else begin
      r_vld_p1      <= ex_valid;
      r_wb_mux_p1   <= ex_wb_mux;
      r_wb_en_p1    <= ex_valid & ex_wb_en & ~w_misalign;
      r_op_dest_p1  <= ex_op_dest;
      r_alu_res_p1  <= ex_alu_res;
      r_misalign_p1 <= w_misalign;
      r_is_load_p1  <= w_is_load;
      r_off_p1      <= w_off;
      r_sign_p1     <= ex_sign;
      r_byte_p1     <= w_is_byte;
    end
  end

  assign mem_valid     = r_vld_p1;
  assign mem_wb_mux    = r_wb_mux_p1;
  assign mem_wb_en     = r_wb_en_p1;
  assign mem_op_dest   = r_op_dest_p1;
  assign mem_alu_res   = r_alu_res_p1;
  assign mem_misalign  = r_misalign_p1;
  assign mem_load_data = r_is_load_p1 ? fmt_load(w_rdata, r_off_p1, r_byte_p1, r_sign_p1) : '0;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench for mem_stage_ws: three instances (0, 2 and 3 wait states) on shared inputs.
module tb_mem_stage_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_byte, ex_sign, ex_wb_mux, ex_wb_en;
  logic [15:0] ex_alu_res, ex_store_data;
  logic [2:0]  ex_op_dest;

  logic [2:0]       stall, vld, wbm, wbe, mis;
  logic [2:0][2:0]  dst;
  logic [2:0][15:0] alu, ld;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  mem_stage_ws #(.DW(16), .AW(8), .RW(3), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_op_dest(ex_op_dest), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_byte(ex_byte), .ex_sign(ex_sign), .ex_wb_mux(ex_wb_mux),
    .ex_wb_en(ex_wb_en), .mem_stall(stall[0]), .mem_valid(vld[0]), .mem_wb_mux(wbm[0]),
    .mem_wb_en(wbe[0]), .mem_op_dest(dst[0]), .mem_alu_res(alu[0]),
    .mem_load_data(ld[0]), .mem_misalign(mis[0]));

  mem_stage_ws #(.DW(16), .AW(8), .RW(3), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_op_dest(ex_op_dest), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_byte(ex_byte), .ex_sign(ex_sign), .ex_wb_mux(ex_wb_mux),
    .ex_wb_en(ex_wb_en), .mem_stall(stall[1]), .mem_valid(vld[1]), .mem_wb_mux(wbm[1]),
    .mem_wb_en(wbe[1]), .mem_op_dest(dst[1]), .mem_alu_res(alu[1]),
    .mem_load_data(ld[1]), .mem_misalign(mis[1]));

  mem_stage_ws #(.DW(16), .AW(8), .RW(3), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_op_dest(ex_op_dest), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_byte(ex_byte), .ex_sign(ex_sign), .ex_wb_mux(ex_wb_mux),
    .ex_wb_en(ex_wb_en), .mem_stall(stall[2]), .mem_valid(vld[2]), .mem_wb_mux(wbm[2]),
    .mem_wb_en(wbe[2]), .mem_op_dest(dst[2]), .mem_alu_res(alu[2]),
    .mem_load_data(ld[2]), .mem_misalign(mis[2]));

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [15:0] sd;
    logic [2:0]  dest;
    logic        rd, wr, byt, sgn, wbm, wbe;
    logic        e_vld, e_wbe, e_mis;
    logic [15:0] e_ld;
  } vec_t;

  vec_t tv [13];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    ex_valid = t.v;   ex_alu_res = t.a;  ex_store_data = t.sd; ex_op_dest = t.dest;
    ex_mem_rd = t.rd; ex_mem_wr = t.wr;  ex_byte = t.byt;      ex_sign = t.sgn;
    ex_wb_mux = t.wbm; ex_wb_en = t.wbe;
  endtask

  task automatic op(input logic v, input logic [15:0] a, input logic [15:0] sd,
                    input logic rd, input logic wr, input logic wbm_i, input logic wbe_i);
    ex_valid = v; ex_alu_res = a; ex_store_data = sd; ex_op_dest = 3'd2;
    ex_mem_rd = rd; ex_mem_wr = wr; ex_byte = 1'b0; ex_sign = 1'b0;
    ex_wb_mux = wbm_i; ex_wb_en = wbe_i;
  endtask

  // Hold current inputs until instance k drops stall, then let the completing edge pass.
  task automatic run_held(input int k, output int c);
    c = 0;
    #1;
    while (stall[k] && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk1("held_op_timeout", c < 20, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    //        v     addr      sdata     dst   rd    wr    byt   sgn   wbm   wbe   e_v   e_we  e_mis e_ld
    tv[0]  = '{1'b1, 16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 16'h0010, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF};
    tv[2]  = '{1'b1, 16'h0011, 16'h1280, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tv[3]  = '{1'b1, 16'h0011, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFF80};
    tv[4]  = '{1'b1, 16'h0011, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0080};
    tv[5]  = '{1'b1, 16'h0010, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h80EF};
    tv[6]  = '{1'b1, 16'h0013, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    tv[7]  = '{1'b1, 16'h0011, 16'hAAAA, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    tv[8]  = '{1'b1, 16'h0010, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h80EF};
    tv[9]  = '{1'b1, 16'h1234, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tv[10] = '{1'b0, 16'h0010, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tv[11] = '{1'b1, 16'h0010, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFEF};
    tv[12] = '{1'b1, 16'h0210, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h80EF};

    rst = 1'b1;
    op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk1 ("rst_valid", vld[k], 1'b0);
      chk1 ("rst_wb_en", wbe[k], 1'b0);
      chk1 ("rst_stall", stall[k], 1'b0);
      chk16("rst_load_data", ld[k], 16'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tv[i]);
      #1 chk1("n0_stall", stall[0], 1'b0);
      @(negedge clk);
      chk1 ("n0_valid", vld[0], tv[i].e_vld);
      chk1 ("n0_wb_en", wbe[0], tv[i].e_wbe);
      chk1 ("n0_misalign", mis[0], tv[i].e_mis);
      chk16("n0_load_data", ld[0], tv[i].e_ld);
      if (tv[i].e_vld) begin
        chk16("n0_alu_res", alu[0], tv[i].a);
        chk16("n0_op_dest", 16'(dst[0]), 16'(tv[i].dest));
        chk1 ("n0_wb_mux", wbm[0], tv[i].wbm);
      end
    end

    // asynchronous reset with live outputs
    op(1'b1, 16'h00FF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1 ("midrst_valid", vld[0], 1'b0);
    chk1 ("midrst_wb_en", wbe[0], 1'b0);
    chk16("midrst_alu_res", alu[0], 16'h0);
    chk16("midrst_load_data", ld[0], 16'h0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b0, 16'h0044, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk1("bubble_valid", vld[0], 1'b0);
    chk1("bubble_wb_en", wbe[0], 1'b0);

    // two wait states
    op(1'b1, 16'h0030, 16'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0);
    run_held(1, cyc);
    chk16("n2_store_stall_cycles", 16'(cyc), 16'd2);
    op(1'b1, 16'h0030, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk1("n2_stall_T", stall[1], 1'b1);
    @(negedge clk);
    chk1("n2_bubble_T", vld[1], 1'b0);
    chk1("n2_stall_T1", stall[1], 1'b1);
    @(negedge clk);
    chk1("n2_bubble_T1", vld[1], 1'b0);
    chk1("n2_wb_en_T1", wbe[1], 1'b0);
    chk1("n2_stall_T2", stall[1], 1'b0);
    @(negedge clk);
    chk1 ("n2_valid", vld[1], 1'b1);
    chk1 ("n2_wb_en", wbe[1], 1'b1);
    chk16("n2_load_data", ld[1], 16'hCAFE);
    chk16("n2_alu_res", alu[1], 16'h0030);
    op(1'b1, 16'h0042, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk1("n2_alu_no_stall", stall[1], 1'b0);
    @(negedge clk);
    chk1 ("n2_alu_valid", vld[1], 1'b1);
    chk16("n2_alu_res_T3", alu[1], 16'h0042);
    chk16("n2_alu_load_data", ld[1], 16'h0);

    // three wait states, reset during the wait of a store
    rst = 1'b1;
    op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b1, 16'h0020, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0);
    run_held(2, cyc);
    chk16("n3_store_stall_cycles", 16'(cyc), 16'd3);
    op(1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk1("n3_stall_in_wait", stall[2], 1'b1);
    rst = 1'b1;
    op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("n3_rst_stall", stall[2], 1'b0);
    chk1("n3_rst_valid", vld[2], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b1, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_held(2, cyc);
    chk16("n3_load_stall_cycles", 16'(cyc), 16'd3);
    chk1 ("n3_load_valid", vld[2], 1'b1);
    chk1 ("n3_load_misalign", mis[2], 1'b0);
    chk16("n3_load_data", ld[2], 16'h5555);
    op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
